// File: rtl/arith_pkg.sv
// Shared arithmetic helpers for the normalizer datapath.
package arith_pkg;

    // Width of a shift distance / leading-zero count for an n-bit operand.
    function automatic int clz_width(input int n);
        return $clog2(n);
    endfunction

    // Generic valid/data pair used by neighbouring datapath stages.
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } hs_word_t;

endpackage

// File: rtl/normalizer_pipe_if.sv
// Handshake bundle for the normalizer: operand in, normalized result out.
interface normalizer_pipe_if #(
    parameter int N = 32
);
    import arith_pkg::*;

    localparam int D_WIDTH = clz_width(N);

    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       in_x;
    logic               out_valid;
    logic               out_ready;
    logic [N-1:0]       out_z;
    logic [D_WIDTH-1:0] out_shift;
    logic               out_zero;

    // Producer/consumer side.
    modport master (
        output in_valid, in_x, out_ready,
        input  in_ready, out_valid, out_z, out_shift, out_zero
    );

    // Normalizer side.
    modport slave (
        input  in_valid, in_x, out_ready,
        output in_ready, out_valid, out_z, out_shift, out_zero
    );

endinterface

// File: rtl/barrel_shifter.sv
// Logarithmic left barrel shifter: stage gi shifts by 2**gi when d[gi] is set.
module barrel_shifter
    import arith_pkg::*;
#(
    parameter  int N       = 32,
    localparam int D_WIDTH = clz_width(N)
) (
    input  logic [N-1:0]       x,
    input  logic [D_WIDTH-1:0] d,
    output logic [N-1:0]       y
);
    logic [N-1:0] w_stage [D_WIDTH+1];

    assign w_stage[0] = x;

    genvar gi;
    generate
        for (gi = 0; gi < D_WIDTH; gi++) begin : g_stage
            assign w_stage[gi+1] = d[gi] ? (w_stage[gi] << (1 << gi)) : w_stage[gi];
        end
    endgenerate

    assign y = w_stage[D_WIDTH];

endmodule

// File: rtl/normalizer_pipe_lzc.sv
// Combinational leading-zero counter built as a binary tree of log2 depth.
// The operand is padded at the LSB end with zeros up to a power of two, so
// padding never contributes a leading one. An all-zero operand reports
// count 0 with zero = 1.
module leading_zero_counter
    import arith_pkg::*;
#(
    parameter  int N       = 32,
    localparam int D_WIDTH = clz_width(N)
) (
    input  logic [N-1:0]       x,
    output logic [D_WIDTH-1:0] count,
    output logic               zero
);
    localparam int P = 1 << D_WIDTH;

    logic [P-1:0] w_x_pad;

    generate
        if (P > N) begin : g_pad
            assign w_x_pad = {x, {(P-N){1'b0}}};
        end else begin : g_nopad
            assign w_x_pad = x;
        end
    endgenerate

    // Level 0 holds one node per bit, node 0 being the MSB. Each higher level
    // merges pairs: the left child covers the more significant half.
    genvar gi, gj;
    generate
        for (gi = 0; gi <= D_WIDTH; gi++) begin : g_lvl
            localparam int NODES = P >> gi;
            logic               w_v [NODES];
            logic [D_WIDTH-1:0] w_c [NODES];
            for (gj = 0; gj < NODES; gj++) begin : g_node
                if (gi == 0) begin : g_leaf
                    assign w_v[gj] = w_x_pad[P-1-gj];
                    assign w_c[gj] = '0;
                end else begin : g_merge
                    localparam logic [D_WIDTH-1:0] WEIGHT = D_WIDTH'(1 << (gi - 1));
                    logic               w_v_hi, w_v_lo;
                    logic [D_WIDTH-1:0] w_c_hi, w_c_lo;
                    assign w_v_hi  = g_lvl[gi-1].w_v[2*gj];
                    assign w_v_lo  = g_lvl[gi-1].w_v[2*gj+1];
                    assign w_c_hi  = g_lvl[gi-1].w_c[2*gj];
                    assign w_c_lo  = g_lvl[gi-1].w_c[2*gj+1];
                    assign w_v[gj] = w_v_hi | w_v_lo;
                    assign w_c[gj] = w_v_hi ? w_c_hi : (w_c_lo | WEIGHT);
                end
            end
        end
    endgenerate

    assign zero  = ~g_lvl[D_WIDTH].w_v[0];
    assign count = zero ? '0 : g_lvl[D_WIDTH].w_c[0];

endmodule

// File: rtl/normalizer_pipe.sv
// Two-stage left normalizer: stage 1 registers the operand with its
// leading-zero count, stage 2 registers the shifted result. Both stages use
// a skid-free valid/ready scheme that advances whenever the stage ahead
// frees up, giving one result per cycle at a latency of two edges.
module normalizer_pipe
    import arith_pkg::*;
#(
    parameter int N = 32
) (
    input logic             clk,
    input logic             rst_n,
    normalizer_pipe_if.slave bus
);
    localparam int D_WIDTH = clz_width(N);

    logic               r_s1_valid;
    logic [N-1:0]       r_s1_x;
    logic [D_WIDTH-1:0] r_s1_lzc;
    logic               r_s1_zero;

    logic               r_out_valid;
    logic [N-1:0]       r_out_z;
    logic [D_WIDTH-1:0] r_out_shift;
    logic               r_out_zero;

    logic [D_WIDTH-1:0] w_lzc;
    logic               w_zero;
    logic [N-1:0]       w_shifted;
    logic               w_s1_en;
    logic               w_s2_en;

    leading_zero_counter #(.N(N)) u_lzc (
        .x     (bus.in_x),
        .count (w_lzc),
        .zero  (w_zero)
    );

    barrel_shifter #(.N(N)) u_shift (
        .x (r_s1_x),
        .d (r_s1_lzc),
        .y (w_shifted)
    );

    assign w_s2_en = !r_out_valid || out_ready_w();
    assign w_s1_en = !r_s1_valid || w_s2_en;

    function automatic logic out_ready_w();
        return bus.out_ready;
    endfunction

    // Stage 1: capture operand, its leading-zero count and zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_lzc   <= '0;
            r_s1_zero  <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= bus.in_valid;
            r_s1_x     <= bus.in_x;
            r_s1_lzc   <= w_lzc;
            r_s1_zero  <= w_zero;
        end
    end

    // Stage 2: capture the shifted result; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_z     <= '0;
            r_out_shift <= '0;
            r_out_zero  <= 1'b0;
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_valid;
            r_out_z     <= w_shifted;
            r_out_shift <= r_s1_lzc;
            r_out_zero  <= r_s1_zero;
        end
    end

    assign bus.in_ready  = w_s1_en;
    assign bus.out_valid = r_out_valid;
    assign bus.out_z     = r_out_z;
    assign bus.out_shift = r_out_shift;
    assign bus.out_zero  = r_out_zero;

endmodule

// File: tb/tb_normalizer_pipe.sv
// Bench for normalizer_pipe: drives a 32-bit and a 24-bit instance and checks
// both against a queue model of in-flight operands.
module tb_normalizer_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    normalizer_pipe_if #(.N(32)) if32 ();
    normalizer_pipe_if #(.N(24)) if24 ();

    normalizer_pipe #(.N(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    normalizer_pipe #(.N(24)) dut24 (.clk(clk), .rst_n(rst_n), .bus(if24));

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] z;
        int          sh;
        bit          zr;
        int          t;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    bit          stall_prev [2];
    logic [31:0] prev_z     [2];
    int          prev_sh    [2];
    bit          prev_zr    [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference: count zeros from the top of a w-bit operand, shift them out.
    function automatic exp_t ref_norm(input logic [31:0] x, input int w, input int t);
        exp_t e;
        e.t  = t;
        e.z  = '0;
        e.sh = 0;
        e.zr = (x == 0);
        if (x != 0) begin
            while (x[w-1-e.sh] == 1'b0) e.sh++;
            e.z = 32'((64'(x) << e.sh) & ((64'd1 << w) - 64'd1));
        end
        return e;
    endfunction

    task automatic mon_step(input int w, input int width,
                            input logic iv, input logic ir, input logic [31:0] ix,
                            input logic ov, input logic ordy, input logic [31:0] oz,
                            input int osh, input logic ozr);
        string tag;
        int    n;
        exp_t  h;
        bit    exp_valid;
        tag = (w == 0) ? "n32" : "n24";
        n   = (w == 0) ? q0.size() : q1.size();
        check({tag, " in_ready"}, 64'(ir), 64'((n < 2) || ordy));
        exp_valid = 1'b0;
        if (n > 0) begin
            h = (w == 0) ? q0[0] : q1[0];
            exp_valid = (cyc >= h.t + 2);
        end
        check({tag, " out_valid"}, 64'(ov), 64'(exp_valid));
        if (stall_prev[w] && ov) begin
            check({tag, " stall z"},     64'(oz),  64'(prev_z[w]));
            check({tag, " stall shift"}, 64'(osh), 64'(prev_sh[w]));
            check({tag, " stall zero"},  64'(ozr), 64'(prev_zr[w]));
        end
        if (ov && exp_valid) begin
            check({tag, " out_z"},     64'(oz),  64'(h.z));
            check({tag, " out_shift"}, 64'(osh), 64'(h.sh));
            check({tag, " out_zero"},  64'(ozr), 64'(h.zr));
            if (ordy) begin
                if (w == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                $display("[cyc %0d] %s result z=%h shift=%0d zero=%0d", cyc, tag, oz, osh, ozr);
            end
        end
        stall_prev[w] = ov && !ordy;
        prev_z[w]     = oz;
        prev_sh[w]    = osh;
        prev_zr[w]    = ozr;
        if (iv && ir) begin
            if (w == 0) q0.push_back(ref_norm(ix, width, cyc));
            else        q1.push_back(ref_norm(ix, width, cyc));
        end
    endtask

    // Compare process: evaluates every falling edge, between active edges.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                stall_prev[0] = 1'b0;
                stall_prev[1] = 1'b0;
                check("n32 reset out_valid", 64'(if32.out_valid), 64'd0);
                check("n32 reset in_ready",  64'(if32.in_ready),  64'd1);
                check("n24 reset out_valid", 64'(if24.out_valid), 64'd0);
                check("n24 reset in_ready",  64'(if24.in_ready),  64'd1);
            end else begin
                mon_step(0, 32, if32.in_valid, if32.in_ready, if32.in_x,
                         if32.out_valid, if32.out_ready, if32.out_z,
                         int'(if32.out_shift), if32.out_zero);
                mon_step(1, 24, if24.in_valid, if24.in_ready, 32'(if24.in_x),
                         if24.out_valid, if24.out_ready, 32'(if24.out_z),
                         int'(if24.out_shift), if24.out_zero);
            end
        end
    end

    // Single operand on the 32-bit pipe with literal expectations and latency.
    task automatic dir32(input logic [31:0] x, input logic [31:0] ez, input int es, input bit ezr);
        @(posedge clk); #1;
        if32.in_valid = 1'b1; if32.in_x = x; if32.out_ready = 1'b1;
        @(negedge clk);
        check($sformatf("dir32 %h accepted", x), 64'(if32.in_ready), 64'd1);
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        @(negedge clk);
        check($sformatf("dir32 %h early valid", x), 64'(if32.out_valid), 64'd0);
        @(negedge clk);
        check($sformatf("dir32 %h valid", x), 64'(if32.out_valid), 64'd1);
        check($sformatf("dir32 %h z", x),     64'(if32.out_z),     64'(ez));
        check($sformatf("dir32 %h shift", x), 64'(if32.out_shift), 64'(es));
        check($sformatf("dir32 %h zero", x),  64'(if32.out_zero),  64'(ezr));
    endtask

    task automatic dir24(input logic [23:0] x, input logic [23:0] ez, input int es, input bit ezr);
        @(posedge clk); #1;
        if24.in_valid = 1'b1; if24.in_x = x; if24.out_ready = 1'b1;
        @(posedge clk); #1;
        if24.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check($sformatf("dir24 %h valid", x), 64'(if24.out_valid), 64'd1);
        check($sformatf("dir24 %h z", x),     64'(if24.out_z),     64'(ez));
        check($sformatf("dir24 %h shift", x), 64'(if24.out_shift), 64'(es));
        check($sformatf("dir24 %h zero", x),  64'(if24.out_zero),  64'(ezr));
    endtask

    initial begin
        int acc;
        rst_n          = 1'b0;
        if32.in_valid  = 1'b0; if32.in_x = '0; if32.out_ready = 1'b1;
        if24.in_valid  = 1'b0; if24.in_x = '0; if24.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed literal vectors
        dir32(32'h0000_0001, 32'h8000_0000, 31, 1'b0);
        dir32(32'h8000_0000, 32'h8000_0000, 0,  1'b0);
        dir32(32'h0000_0000, 32'h0000_0000, 0,  1'b1);
        dir32(32'h0003_5000, 32'hD400_0000, 14, 1'b0);
        dir24(24'h00_0001,   24'h80_0000,   23, 1'b0);
        dir24(24'h00_0000,   24'h00_0000,   0,  1'b1);
        dir24(24'h0F_FFFF,   24'hFF_FFF0,   4,  1'b0);

        // Back-to-back stream with both handshakes held high
        acc = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if32.in_valid  = 1'b1;
            if32.in_x      = $urandom >> $urandom_range(0, 31);
            if32.out_ready = 1'b1;
            @(negedge clk);
            if (if32.in_ready) acc++;
        end
        @(posedge clk); #1 if32.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b accepts", 64'(acc), 64'd100);

        // Backpressure: consumer stalls for 5 cycles
        acc = 0;
        @(posedge clk); #1;
        if32.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if32.in_valid = 1'b1;
            if32.in_x     = 32'h0000_0F00 << i;
            @(negedge clk);
            check($sformatf("bp in_ready cycle %0d", i), 64'(if32.in_ready), 64'(i < 2));
            if (if32.in_ready) acc++;
        end
        @(posedge clk); #1;
        if32.in_valid = 1'b0; if32.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("bp accepts", 64'(acc), 64'd2);

        // Reset with two operands in flight
        @(posedge clk); #1;
        if32.out_ready = 1'b0; if32.in_valid = 1'b1; if32.in_x = 32'h0000_1234;
        @(posedge clk); #1 if32.in_x = 32'h0000_0005;
        @(posedge clk); #1 if32.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; if32.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post-reset out_valid", 64'(if32.out_valid), 64'd0);
        check("post-reset in_ready",  64'(if32.in_ready),  64'd1);
        repeat (4) @(negedge clk);

        // Random traffic on the 24-bit pipe
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if24.in_valid  = 1'($urandom_range(0, 1));
            if24.out_ready = ($urandom_range(0, 3) != 0);
            if24.in_x      = 24'($urandom >> $urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) if24.in_x = '0;
        end
        @(posedge clk); #1;
        if24.in_valid = 1'b0; if24.out_ready = 1'b1;
        repeat (5) @(negedge clk);

        check("n32 drained", 64'(q0.size()), 64'd0);
        check("n24 drained", 64'(q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/normalizer_pipe.md
# normalizer_pipe

Two-stage pipelined left-normalizer. It counts the leading zeros of an N-bit operand, then shifts the operand left by that count so that its MSB is 1. It sits between a producer (adder or multiplier datapath) and rounding/packing logic, and drives the codebase's `barrel_shifter` with the computed shift distance. Valid/ready handshakes on both sides, full throughput of one operand per cycle, latency 2 cycles.

## Interface
Parameters:
- `N`, 32, operand width; N >= 2, need not be a power of two.
- `D_WIDTH`, `$clog2(N)`, shift-distance width; derived, never overridden.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: `in_x` holds an operand.
- `in_ready` output 1: block accepts the operand this cycle.
- `in_x` input N: operand to normalize.
- `out_valid` output 1: output fields hold a result.
- `out_ready` input 1: consumer accepts the result this cycle.
- `out_z` output N: normalized value, `in_x << out_shift`.
- `out_shift` output D_WIDTH: leading-zero count applied.
- `out_zero` output 1: operand was all zeros.

## Operation
- The input transfers when `in_valid && in_ready`. The output transfers when `out_valid && out_ready`.
- Stage 1 (`s1`) registers:
  - `s1_valid`
  - `s1_x = in_x`
  - `s1_lzc` = number of leading zeros of `in_x`, range 0..N-1
  - `s1_zero = (in_x == 0)`
- Stage 2 (`s2`, the output registers) registers, from `s1`:
  - `out_z` = barrel-shifter result of `s1_x` by `s1_lzc`
  - `out_shift = s1_lzc`
  - `out_zero = s1_zero`
  - `out_valid`
- Zero operand:
  - `s1_lzc` is forced to 0, so `out_shift = 0`, `out_z = 0`, `out_zero = 1`.
  - A count of N is never encoded.
- Non-zero operand: `out_z[N-1] = 1` always, and `out_zero = 0`.
- Stall and flow control:
  - `s2_en = !out_valid || out_ready`
  - `s1_en = !s1_valid || s2_en`
  - `in_ready = s1_en`, purely combinational from state and `out_ready`. No dependency on `in_valid`.
- `s2` loads when `s2_en`. Its valid bit becomes `s1_valid`.
- `s1` loads when `s1_en`. Its valid bit becomes `in_valid`.
- Data registers may load while their valid bit is 0. Data is don't-care when not valid.
- No combinational path from `in_*` to `out_*`.
- Output stability: while `out_valid && !out_ready`, `out_z`, `out_shift` and `out_zero` hold constant.

## Timing
- Reset (asynchronous assert, synchronous release to `clk`):
  - `s1_valid = 0`, `out_valid = 0`, `out_z = 0`, `out_shift = 0`, `out_zero = 0`.
  - Therefore `in_ready = 1` during and immediately after reset.
- Latency: an operand accepted at edge k is presented at `out_valid` after edge k+1.
- Throughput: with `out_ready` held high, one result per cycle with no bubbles.
- Simultaneous accept and drain: when the pipe is full and `out_ready = 1`, `in_ready = 1` in the same cycle. All stages advance together.
- Full pipe with `out_ready = 0`:
  - `in_ready = 0`.
  - Both stages hold.
  - At most 2 operands are in flight.
- Reset mid-operation: in-flight operands are discarded. No output transfer occurs for them after release.

## Structure
- Package `arith_pkg`:
  - helper function `clz_width(N)`, returning `$clog2(N)`
  - shared handshake struct type for `{valid, data}` if used elsewhere
- Sub-module `leading_zero_counter` (combinational):
  - parameter `N`
  - input `x`
  - outputs `count[D_WIDTH-1:0]` and `zero`
  - implemented as a tree, O(log N) depth
- The existing `barrel_shifter` is instantiated between `s1` and `s2` with `x = s1_x`, `d = s1_lzc`.

## Test plan
- Reset: hold `rst_n = 0` mid-stream with 2 operands in flight, then release. Expect `out_valid = 0`, `in_ready = 1`, and no stale result ever emitted.
- Values, N=32, `out_ready = 1`:
  - `in_x = 0x0000_0001` gives `out_z = 0x8000_0000`, `out_shift = 31`, `out_zero = 0`, exactly 2 cycles after accept.
  - `in_x = 0x8000_0000` gives `out_z = 0x8000_0000`, `out_shift = 0`.
- Zero operand: `in_x = 0` gives `out_z = 0`, `out_shift = 0`, `out_zero = 1`.
- Back-to-back stream: 100 random operands with `in_valid` and `out_ready` held high. Expect one result per cycle, in order, each matching the model `in_x << clz(in_x)`.
- Backpressure: `out_ready = 0` for 5 cycles with `in_valid = 1`.
  - Expect `in_ready` to drop after exactly 2 accepts.
  - Output fields stay stable while stalled.
  - On release, both results drain in order with no loss or duplication.
- Non-power-of-two `N = 24`, `in_x = 0x00_0001`: expect `out_shift = 23`, `out_z = 0x80_0000`. Then random traffic with random `in_valid` and `out_ready` against the reference model.
